// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared widths and FSM state encoding for the systolic array sequencer.
// Imported by the interface, the delay line and the sequencer top.
package sys_pkg;

  localparam int PIX_W = 8;
  localparam int WGT_W = 8;
  localparam int ACC_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Bundle of job control, weight/pixel streams and PE-grid edge signals.
// master is the sequencer side; slave is the front end / grid side.
interface systolic_seq_ctrl_if
  import sys_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 16
);

  logic                    start;
  logic [LEN_W-1:0]        cfg_len;
  logic                    busy;
  logic                    done;

  logic                    w_valid;
  logic                    w_ready;
  logic [COLS*WGT_W-1:0]   w_data;

  logic                    pix_valid;
  logic                    pix_ready;
  logic [ROWS*PIX_W-1:0]   pix_data;

  logic                    arr_en_weight;
  logic [COLS*WGT_W-1:0]   arr_weight;
  logic [ROWS*PIX_W-1:0]   arr_west;
  logic [COLS*ACC_W-1:0]   arr_south;

  logic                    res_valid;
  logic [COLS*ACC_W-1:0]   res_data;

  modport master (
    input  start, cfg_len, w_valid, w_data, pix_valid, pix_data, arr_south,
    output busy, done, w_ready, pix_ready, arr_en_weight, arr_weight, arr_west,
           res_valid, res_data
  );

  modport slave (
    output start, cfg_len, w_valid, w_data, pix_valid, pix_data, arr_south,
    input  busy, done, w_ready, pix_ready, arr_en_weight, arr_weight, arr_west,
           res_valid, res_data
  );

endinterface

// File: rtl/systolic_seq_ctrl_delay_line.sv
// Fixed-depth register chain with async active-low clear; DEPTH=0 is a wire.
// Used for the west-edge input skew and the south-edge output deskew.
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = clk ^ reset_n;
      assign q = d;
    end else begin : g_regs
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Weight-stationary systolic array sequencer: weight load, skewed pixel
// streaming, drain and output deskew. Define SYSTOLIC_RELU_EN to clamp results.
module systolic_seq_ctrl
  import sys_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 16
) (
  input logic                clk,
  input logic                reset_n,
  systolic_seq_ctrl_if.master bus
);

  localparam int TAG_N  = ROWS + COLS;
  localparam int BEAT_W = $clog2(ROWS + 1);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  vec_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [TAG_N-1:0]  tag_q;
  logic              res_valid_q;
  logic              en_weight_q;
  logic [COLS*WGT_W-1:0] weight_q;
  logic              w_hs;
  logic              pix_hs;
  logic              last_beat;
  logic              last_vec;

  function automatic logic [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] x);
`ifdef SYSTOLIC_RELU_EN
    return x[ACC_W-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  assign w_hs      = bus.w_valid && (state == LOAD_W);
  assign pix_hs    = bus.pix_valid && (state == STREAM);
  assign last_beat = (beat_cnt == BEAT_W'(ROWS - 1));
  assign last_vec  = (vec_cnt == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.w_ready   = 1'b0;
    bus.pix_ready = 1'b0;
    unique case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        bus.w_ready = 1'b1;
        if (w_hs && last_beat) state_nxt = (len_q == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        bus.pix_ready = 1'b1;
        if (pix_hs && last_vec) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (tag_q == '0) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job counters and the weight register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      vec_cnt     <= '0;
      beat_cnt    <= '0;
      en_weight_q <= 1'b0;
      weight_q    <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        len_q    <= bus.cfg_len;
        vec_cnt  <= '0;
        beat_cnt <= '0;
      end else begin
        if (w_hs)   beat_cnt <= beat_cnt + BEAT_W'(1);
        if (pix_hs) vec_cnt  <= vec_cnt + LEN_W'(1);
      end
      en_weight_q <= w_hs;
      if (w_hs) weight_q <= bus.w_data;
    end
  end

  // Tag chain spans the skew, the grid and the deskew, so it doubles as the drain detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      tag_q       <= {tag_q[TAG_N-2:0], pix_hs};
      res_valid_q <= tag_q[TAG_N-1];
    end
  end

  assign bus.arr_en_weight = en_weight_q;
  assign bus.arr_weight    = weight_q;
  assign bus.res_valid     = res_valid_q;

  // Input skew: row r reaches column 0 r cycles after row 0
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [PIX_W-1:0] inj;
    assign inj = pix_hs ? bus.pix_data[r*PIX_W +: PIX_W] : '0;
    delay_line #(.WIDTH(PIX_W), .DEPTH(1 + r)) u_dl (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (inj),
      .q       (bus.arr_west[r*PIX_W +: PIX_W])
    );
  end

  // Output deskew: column c leaves the grid c cycles late, so it waits COLS-1-c less
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    logic signed [ACC_W-1:0] dly;
    logic [ACC_W-1:0]        res_q;

    delay_line #(.WIDTH(ACC_W), .DEPTH(COLS - 1 - c)) u_dl (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (bus.arr_south[c*ACC_W +: ACC_W]),
      .q       (dly)
    );

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) res_q <= '0;
      else          res_q <= relu(dly);
    end

    assign bus.res_data[c*ACC_W +: ACC_W] = res_q;
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a behavioural 4x4 PE grid on the
// array side; expected results are hand-computed constants.
module tb_systolic_seq_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int LEN_W = 16;

  localparam logic [31:0] ID_VEC [3]    = '{32'h0403_0201, 32'h281E_140A, 32'h0007_80FF};
  localparam int          EXP_ID [3][4] = '{'{1, 2, 3, 4}, '{10, 20, 30, 40}, '{255, 128, 7, 0}};
  localparam int          EXP_BB [2][4] = '{'{4, 8, 12, 16}, '{26, 52, 78, 104}};

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  systolic_seq_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) bus ();

  systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural weight-stationary PE grid
  logic signed [7:0] pe_w [ROWS][COLS];
  logic        [7:0] pe_e [ROWS][COLS];
  logic       [31:0] pe_s [ROWS][COLS];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          pe_w[r][c] <= '0;
          pe_e[r][c] <= '0;
          pe_s[r][c] <= '0;
        end
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          logic [7:0]  west;
          logic [31:0] north;
          int          prod;
          if (c == 0) west = bus.arr_west[8*r +: 8];
          else        west = pe_e[r][c-1];
          if (r == 0) north = '0;
          else        north = pe_s[r-1][c];
          prod = int'(west) * int'(pe_w[r][c]);
          pe_e[r][c] <= west;
          pe_s[r][c] <= north + 32'(prod);
          if (bus.arr_en_weight) begin
            if (r == 0) pe_w[r][c] <= bus.arr_weight[8*c +: 8];
            else        pe_w[r][c] <= pe_w[r-1][c];
          end
        end
    end
  end

  always_comb begin
    bus.arr_south = '0;
    for (int c = 0; c < COLS; c++) bus.arr_south[32*c +: 32] = pe_s[ROWS-1][c];
  end

  // Event logs
  int cyc = 0;
  int pix_hs_cyc[$];
  int w_hs_cyc[$];
  int res_cyc[$];
  int done_cyc[$];
  logic [127:0] res_val[$];
  int en_cnt = 0;
  int pix_rdy_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.pix_valid && bus.pix_ready) pix_hs_cyc.push_back(cyc);
    if (bus.w_valid && bus.w_ready) w_hs_cyc.push_back(cyc);
  end

  always @(negedge clk) begin
    if (bus.res_valid) begin
      res_cyc.push_back(cyc - 1);
      res_val.push_back(bus.res_data);
    end
    if (bus.done) done_cyc.push_back(cyc - 1);
    if (bus.arr_en_weight) en_cnt <= en_cnt + 1;
    if (bus.pix_ready) pix_rdy_cnt <= pix_rdy_cnt + 1;
  end

  int checks = 0;
  int passes = 0;
  int stall_cnt = 0;
  int rb, db, pb, wb, eb, prb;

  function automatic logic [31:0] col(input logic [127:0] v, input int c);
    return v[32*c +: 32];
  endfunction

  task automatic mark();
    rb = res_cyc.size();
    db = done_cyc.size();
    pb = pix_hs_cyc.size();
    wb = w_hs_cyc.size();
    eb = en_cnt;
    prb = pix_rdy_cnt;
    stall_cnt = 0;
  endtask

  task automatic do_start(input logic [15:0] len);
    bus.start = 1'b1;
    bus.cfg_len = len;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d);
    int g = 0;
    bus.w_valid = 1'b1;
    bus.w_data = d;
    while (bus.w_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    if (g >= 20) stall_cnt++;
    @(negedge clk);
    bus.w_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [31:0] d);
    int g = 0;
    bus.pix_valid = 1'b1;
    bus.pix_data = d;
    while (bus.pix_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    if (g >= 20) stall_cnt++;
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (bus.busy !== 1'b0 && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) stall_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else passes++;
    checks++; if (bus.w_ready !== 1'b0) $display("FAIL rst_w_ready: got %b want 0", bus.w_ready); else passes++;
    checks++; if (bus.pix_ready !== 1'b0) $display("FAIL rst_pix_ready: got %b want 0", bus.pix_ready); else passes++;
    checks++; if (bus.arr_en_weight !== 1'b0) $display("FAIL rst_en_weight: got %b want 0", bus.arr_en_weight); else passes++;
    checks++; if (bus.arr_weight !== 32'h0) $display("FAIL rst_arr_weight: got %h want 0", bus.arr_weight); else passes++;
    checks++; if (bus.arr_west !== 32'h0) $display("FAIL rst_arr_west: got %h want 0", bus.arr_west); else passes++;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); else passes++;
    checks++; if (bus.res_data !== 128'h0) $display("FAIL rst_res_data: got %h want 0", bus.res_data); else passes++;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", bus.busy); else passes++;
  endtask

  task automatic test_ones();
    logic [31:0] got;
    int v;
    mark();
    do_start(16'd1);
    for (int k = 0; k < 4; k++) send_w(32'h0101_0101);
    send_pix(32'h0403_0201);
    wait_idle();
    checks++; if (stall_cnt !== 0) $display("FAIL ones_stall: got %0d stalls want 0", stall_cnt); else passes++;
    checks++; if (res_cyc.size() - rb !== 1) $display("FAIL ones_count: got %0d want 1", res_cyc.size() - rb); else passes++;
    for (int c = 0; c < COLS; c++) begin
      got = (res_val.size() > rb) ? col(res_val[rb], c) : 32'hxxxx_xxxx;
      checks++; if (got !== 32'd10) $display("FAIL ones_col%0d: got %0d want 10", c, got); else passes++;
    end
    v = (res_cyc.size() > rb && pix_hs_cyc.size() > pb) ? res_cyc[rb] - pix_hs_cyc[pb] : -1;
    checks++; if (v !== 8) $display("FAIL ones_latency: got %0d want 8", v); else passes++;
    checks++; if (done_cyc.size() - db !== 1) $display("FAIL ones_done_count: got %0d want 1", done_cyc.size() - db); else passes++;
    v = (done_cyc.size() > db && res_cyc.size() > rb) ? done_cyc[db] - res_cyc[rb] : -1;
    checks++; if (v !== 1) $display("FAIL ones_done_after_res: got %0d want 1", v); else passes++;
    checks++; if (en_cnt - eb !== 4) $display("FAIL ones_en_weight: got %0d want 4", en_cnt - eb); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int v;
    mark();
    do_start(16'd3);
    for (int k = 0; k < 4; k++) send_w(32'h1 << (8 * (3 - k)));
    for (int i = 0; i < 3; i++) send_pix(ID_VEC[i]);
    wait_idle();
    checks++; if (stall_cnt !== 0) $display("FAIL b2b_stall: got %0d stalls want 0", stall_cnt); else passes++;
    checks++; if (res_cyc.size() - rb !== 3) $display("FAIL b2b_count: got %0d want 3", res_cyc.size() - rb); else passes++;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < COLS; c++) begin
        got = (res_val.size() > rb + i) ? col(res_val[rb + i], c) : 32'hxxxx_xxxx;
        checks++; if (got !== 32'(EXP_ID[i][c])) $display("FAIL b2b_v%0d_col%0d: got %0d want %0d", i, c, got, EXP_ID[i][c]); else passes++;
      end
    for (int i = 1; i < 3; i++) begin
      v = (res_cyc.size() > rb + i) ? res_cyc[rb + i] - res_cyc[rb + i - 1] : -1;
      checks++; if (v !== 1) $display("FAIL b2b_gap%0d: got %0d want 1", i, v); else passes++;
    end
  endtask

  task automatic test_negative();
    logic [31:0] got;
    logic [31:0] want;
`ifdef SYSTOLIC_RELU_EN
    want = 32'h0000_0000;
`else
    want = 32'hFFFF_FF01;
`endif
    mark();
    do_start(16'd1);
    for (int k = 0; k < 4; k++) send_w(32'hFFFF_FFFF);
    send_pix(32'h0000_00FF);
    wait_idle();
    checks++; if (res_cyc.size() - rb !== 1) $display("FAIL neg_count: got %0d want 1", res_cyc.size() - rb); else passes++;
    for (int c = 0; c < COLS; c++) begin
      got = (res_val.size() > rb) ? col(res_val[rb], c) : 32'hxxxx_xxxx;
      checks++; if (got !== want) $display("FAIL neg_col%0d: got %h want %h", c, got, want); else passes++;
    end
  endtask

  task automatic test_bubbles();
    logic [31:0] got;
    int v;
    mark();
    do_start(16'd2);
    send_w(32'h0403_0201);
    bus.start = 1'b1;
    bus.cfg_len = 16'd5;
    send_w(32'h0403_0201);
    bus.start = 1'b0;
    send_w(32'h0403_0201);
    send_w(32'h0403_0201);
    send_pix(32'h0101_0101);
    repeat (2) @(negedge clk);
    send_pix(32'h0807_0605);
    wait_idle();
    checks++; if (stall_cnt !== 0) $display("FAIL bub_stall: got %0d stalls want 0", stall_cnt); else passes++;
    checks++; if (res_cyc.size() - rb !== 2) $display("FAIL bub_count: got %0d want 2", res_cyc.size() - rb); else passes++;
    v = (res_cyc.size() > rb + 1) ? res_cyc[rb + 1] - res_cyc[rb] : -1;
    checks++; if (v !== 3) $display("FAIL bub_spacing: got %0d want 3", v); else passes++;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < COLS; c++) begin
        got = (res_val.size() > rb + i) ? col(res_val[rb + i], c) : 32'hxxxx_xxxx;
        checks++; if (got !== 32'(EXP_BB[i][c])) $display("FAIL bub_v%0d_col%0d: got %0d want %0d", i, c, got, EXP_BB[i][c]); else passes++;
      end
    checks++; if (done_cyc.size() - db !== 1) $display("FAIL bub_done_count: got %0d want 1", done_cyc.size() - db); else passes++;
  endtask

  task automatic test_len_zero();
    int v;
    mark();
    bus.pix_valid = 1'b1;
    bus.pix_data = 32'hFFFF_FFFF;
    do_start(16'd0);
    for (int k = 0; k < 4; k++) send_w(32'h0101_0101);
    bus.pix_valid = 1'b1;
    wait_idle();
    bus.pix_valid = 1'b0;
    checks++; if (stall_cnt !== 0) $display("FAIL len0_stall: got %0d stalls want 0", stall_cnt); else passes++;
    checks++; if (w_hs_cyc.size() - wb !== 4) $display("FAIL len0_beats: got %0d want 4", w_hs_cyc.size() - wb); else passes++;
    checks++; if (pix_rdy_cnt - prb !== 0) $display("FAIL len0_pix_ready: got %0d cycles want 0", pix_rdy_cnt - prb); else passes++;
    checks++; if (res_cyc.size() - rb !== 0) $display("FAIL len0_res: got %0d want 0", res_cyc.size() - rb); else passes++;
    checks++; if (done_cyc.size() - db !== 1) $display("FAIL len0_done_count: got %0d want 1", done_cyc.size() - db); else passes++;
    v = (done_cyc.size() > db && w_hs_cyc.size() > wb + 3) ? done_cyc[db] - w_hs_cyc[wb + 3] : -1;
    checks++; if (v !== 1) $display("FAIL len0_done_timing: got %0d want 1", v); else passes++;
  endtask

  task automatic test_abort();
    mark();
    do_start(16'd3);
    for (int k = 0; k < 4; k++) send_w(32'h0101_0101);
    send_pix(32'h0403_0201);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.pix_ready !== 1'b0) $display("FAIL abort_pix_ready: got %b want 0", bus.pix_ready); else passes++;
    checks++; if (bus.arr_west !== 32'h0) $display("FAIL abort_arr_west: got %h want 0", bus.arr_west); else passes++;
    checks++; if (bus.arr_weight !== 32'h0) $display("FAIL abort_arr_weight: got %h want 0", bus.arr_weight); else passes++;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL abort_res_valid: got %b want 0", bus.res_valid); else passes++;
    checks++; if (bus.res_data !== 128'h0) $display("FAIL abort_res_data: got %h want 0", bus.res_data); else passes++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (done_cyc.size() - db !== 0) $display("FAIL abort_done: got %0d pulses want 0", done_cyc.size() - db); else passes++;
    checks++; if (res_cyc.size() - rb !== 0) $display("FAIL abort_res: got %0d want 0", res_cyc.size() - rb); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL abort_idle: got %b want 0", bus.busy); else passes++;
    test_ones();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cfg_len = '0;
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    test_reset();
    test_ones();
    test_back_to_back();
    test_negative();
    test_bubbles();
    test_len_zero();
    test_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for a ROWS x COLS weight-stationary systolic array of MAC processing elements.
- Each job has two phases. First it loads one weight row per accepted beat into the top of the array, ROWS beats in total. Then it streams cfg_len pixel vectors into the west edge with per-row skew.
- Bottom-row partial sums are deskewed into one aligned result vector per input vector.
- Sits between the DMA/stream front end and the PE grid. The top-row in_north inputs are tied to 0 outside this block.

Parameters:
- ROWS, 4, PE rows; also the pixel vector length.
- COLS, 4, PE columns; also the weight/result vector length.
- LEN_W, 16, width of cfg_len.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job request; honoured only in IDLE.
- cfg_len  in  LEN_W  number of pixel vectors; sampled when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  weight beat ready.
- w_data  in  COLS*8  signed weight row; column c in bits [8c+7:8c].
- pix_valid  in  1  pixel vector valid.
- pix_ready  out  1  pixel vector ready.
- pix_data  in  ROWS*8  unsigned pixels; row r in bits [8r+7:8r].
- arr_en_weight  out  1  to the PE en_weight inputs.
- arr_weight  out  COLS*8  to the top-row in_weight inputs.
- arr_west  out  ROWS*8  to the column-0 in_west inputs, skewed.
- arr_south  in  COLS*32  bottom-row out_south outputs.
- res_valid  out  1  result vector valid; no backpressure.
- res_data  out  COLS*32  signed result; column c in bits [32c+31:32c].

Behaviour:
- Reset: all outputs and internal registers are 0 (including res_data, arr_weight, arr_west, skew/deskew lines); FSM returns to IDLE.
- Reset is asynchronous: assertion mid-job aborts immediately, with no done pulse.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE -> LOAD_W on start. Latch cfg_len; clear the beat and vector counters.
- start is ignored in all other states.
- LOAD_W:
  - w_ready=1.
  - On each handshake, register w_data into arr_weight and assert arr_en_weight=1 for exactly the next cycle; otherwise arr_en_weight=0.
  - Beat k lands in PE row ROWS-1-k: the first beat becomes the bottom row.
  - After ROWS beats, go to STREAM, or to DRAIN if len==0.
- STREAM:
  - pix_ready=1 and arr_en_weight=0.
  - On a handshake, pixel row r enters a delay line of 1+r registers driving arr_west row r.
  - On a cycle with no handshake, zeros are injected as a bubble.
  - A valid-tag shift register records which slots are real vectors.
  - After cfg_len handshakes, go to DRAIN; pix_ready is 0 from that cycle.
- DRAIN: keep injecting zeros until the valid-tag register is empty, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Deskew and latency:
  - Capture arr_south column c, then delay it COLS-1-c further registers.
  - res_valid rises exactly ROWS+COLS clock edges after the accepting pixel handshake edge (8 for 4x4).
  - Results come out in input order; bubbles produce no res_valid.
- Result arithmetic: res_data[c] = sum over r of zero-extended pixel[r] times signed weight W[r][c], 32-bit two's-complement wrap. The array computes this; the block passes it through unchanged.
- w_valid in non-LOAD_W states and pix_valid in non-STREAM states are ignored, with ready=0.

Optional Feature:
- Macro SYSTOLIC_RELU_EN.
- Defined: each res_data column is clamped to 0 when negative, in the final deskew register. Latency is unchanged.
- Undefined: results pass through signed and unmodified.

Decomposition:
- Package sys_pkg:
  - PIX_W=8, WGT_W=8, ACC_W=32.
  - FSM state enum seq_state_t {IDLE, LOAD_W, STREAM, DRAIN, DONE}.
- Sub-module delay_line:
  - Parameters WIDTH and DEPTH, with DEPTH=0 meaning a wire; async active-low reset.
  - Instantiated once per input skew row and once per output deskew column.

Test Plan:
- All four weight beats {1,1,1,1}, then pixel {1,2,3,4} -> res_data = {10,10,10,10}. res_valid high 8 edges after the pixel handshake, then done.
- Identity weights (beat k has 1 only in column ROWS-1-k), cfg_len=3, three back-to-back vectors -> three consecutive res_valid cycles, each result equal to its input vector.
- Weight -1 in every PE, pixel {255,0,0,0} -> -255 in every column (0 in every column with SYSTOLIC_RELU_EN defined).
- pix_valid gaps (valid 1,0,0,1) with cfg_len=2 -> exactly 2 res_valid pulses, 3 cycles apart, with correct values; no pulse for bubbles.
- cfg_len=0 -> 4 weight beats accepted, pix_ready never high, done 1 cycle after DRAIN, no res_valid.
- reset_n asserted mid-STREAM -> all outputs 0 asynchronously, FSM in IDLE, no done pulse; a fresh start then completes normally.
